drive_controller: RTL

Motion sequencer between the line-tracker decoder and the two drive motors. It takes the tracker's 2-bit steering command, an obstacle-stop request and a run enable, and debounces the command. An FSM selects a per-wheel target duty, and each wheel's duty ramps toward its target once per PWM period. The block generates the left and right PWM outputs that drive the motor driver inputs.

---
 rtl/drive_pkg.sv | 28 ++
 rtl/drive_controller_ramp.sv | 49 ++++
 rtl/drive_controller.sv | 118 +++++++++++
 3 files changed

// File: rtl/drive_pkg.sv
// Shared definitions for the drive controller: tracker codes, FSM states and
// the command-to-state mapping used both in normal running and on obstacle exit.
package drive_pkg;

  localparam logic [1:0] TRK_STOP  = 2'b00;
  localparam logic [1:0] TRK_LEFT  = 2'b01;
  localparam logic [1:0] TRK_RIGHT = 2'b10;
  localparam logic [1:0] TRK_FWD   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FWD     = 3'd1,
    ST_LEFT    = 3'd2,
    ST_RIGHT   = 3'd3,
    ST_STOPPED = 3'd4,
    ST_OBST    = 3'd5
  } state_e;

  function automatic state_e map_track(input logic [1:0] trk);
    case (trk)
      TRK_FWD:   return ST_FWD;
      TRK_LEFT:  return ST_LEFT;
      TRK_RIGHT: return ST_RIGHT;
      default:   return ST_STOPPED;
    endcase
  endfunction

endpackage

// File: rtl/drive_controller_ramp.sv
// Per-wheel duty slew limiter: steps the actual duty toward the target once per
// PWM period, and drops it to zero immediately on an emergency request.
module duty_ramp #(
  parameter int PWM_BITS  = 10,
  parameter int RAMP_STEP = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wrap_i,
  input  logic                force_zero_i,
  input  logic [PWM_BITS-1:0] target_i,
  output logic [PWM_BITS-1:0] actual_o
);

  localparam logic [PWM_BITS:0] STEP_X = (PWM_BITS+1)'(RAMP_STEP);

  logic [PWM_BITS-1:0] actual_q, actual_d;
  logic [PWM_BITS:0]   act_x, tgt_x, up_x;

  // One extra bit of headroom so neither the sum nor the difference wraps.
  assign act_x = {1'b0, actual_q};
  assign tgt_x = {1'b0, target_i};
  assign up_x  = act_x + STEP_X;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    actual_d = actual_q;
    if (force_zero_i) begin
      actual_d = '0;
    end else if (wrap_i) begin
      if (act_x < tgt_x) begin
        actual_d = (up_x > tgt_x) ? target_i : up_x[PWM_BITS-1:0];
      end else if (act_x > tgt_x) begin
        actual_d = ((act_x - tgt_x) > STEP_X) ? actual_q - STEP_X[PWM_BITS-1:0] : target_i;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) actual_q <= '0;
    else       actual_q <= actual_d;
  end

  assign actual_o = actual_q;

endmodule

// File: rtl/drive_controller.sv
// Motion sequencer: debounces the tracker command, selects per-wheel target
// duties from a small FSM, ramps them and generates the two motor PWM outputs.
module drive_controller
  import drive_pkg::*;
#(
  parameter int PWM_BITS     = 10,
  parameter int FWD_DUTY     = 900,
  parameter int TURN_FAST    = 900,
  parameter int TURN_SLOW    = 300,
  parameter int RAMP_STEP    = 64,
  parameter int DEBOUNCE     = 4,
  parameter int CLEAR_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] track_state,
  input  logic       obstacle,
  output logic       left_pwm,
  output logic       right_pwm,
  output logic [2:0] ctrl_state
);

  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int CW = $clog2(CLEAR_CYCLES + 1);
  localparam logic [DW-1:0] DEB_MAX   = DW'(DEBOUNCE);
  localparam logic [CW-1:0] CLR_LAST  = CW'(CLEAR_CYCLES - 1);
  localparam logic [PWM_BITS-1:0] D_FWD  = PWM_BITS'(FWD_DUTY);
  localparam logic [PWM_BITS-1:0] D_FAST = PWM_BITS'(TURN_FAST);
  localparam logic [PWM_BITS-1:0] D_SLOW = PWM_BITS'(TURN_SLOW);

  logic [1:0]          cand_q, cmd_q, cmd_d;
  logic [DW-1:0]       deb_q, deb_d;
  logic [CW-1:0]       clr_q, clr_d;
  state_e              state_q, state_d;
  logic [PWM_BITS-1:0] cnt_q;
  logic [PWM_BITS-1:0] left_tgt, right_tgt, left_duty, right_duty;
  logic                left_pwm_q, right_pwm_q, wrap, force_zero;

  // Debounce: the commit looks at the incoming sample so DEBOUNCE=1 commits at once.
  always_comb begin
    deb_d = (track_state != cand_q) ? DW'(1) : (deb_q == DEB_MAX) ? deb_q : deb_q + DW'(1);
    cmd_d = (deb_d == DEB_MAX) ? track_state : cmd_q;
  end

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    if (!enable) begin
      state_d = ST_IDLE;
      clr_d   = '0;
    end else if (obstacle) begin
      state_d = ST_OBST;
      clr_d   = '0;
    end else if (state_q == ST_OBST) begin
      if (clr_q == CLR_LAST) begin
        state_d = map_track(cmd_q);
        clr_d   = '0;
      end else begin
        clr_d = clr_q + CW'(1);
      end
    end else begin
      state_d = map_track(cmd_q);
    end
  end

  always_comb begin
    left_tgt  = '0;
    right_tgt = '0;
    case (state_q)
      ST_FWD:   begin left_tgt = D_FWD;  right_tgt = D_FWD;  end
      ST_LEFT:  begin left_tgt = D_SLOW; right_tgt = D_FAST; end
      ST_RIGHT: begin left_tgt = D_FAST; right_tgt = D_SLOW; end
      default:  ;
    endcase
  end

  // Zeroing keys off the next state so duties are already 0 on the edge that enters OBST/IDLE.
  assign force_zero = (state_d == ST_OBST) || (state_d == ST_IDLE);
  assign wrap       = (cnt_q == '1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cand_q      <= TRK_STOP;
      cmd_q       <= TRK_STOP;
      deb_q       <= '0;
      clr_q       <= '0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      left_pwm_q  <= 1'b0;
      right_pwm_q <= 1'b0;
    end else begin
      cand_q      <= track_state;
      cmd_q       <= cmd_d;
      deb_q       <= deb_d;
      clr_q       <= clr_d;
      state_q     <= state_d;
      cnt_q       <= cnt_q + PWM_BITS'(1);
      left_pwm_q  <= (cnt_q < left_duty);
      right_pwm_q <= (cnt_q < right_duty);
    end
  end

  duty_ramp #(.PWM_BITS(PWM_BITS), .RAMP_STEP(RAMP_STEP)) u_left_ramp (
    .clk(clk), .reset(reset), .wrap_i(wrap), .force_zero_i(force_zero),
    .target_i(left_tgt), .actual_o(left_duty)
  );

  duty_ramp #(.PWM_BITS(PWM_BITS), .RAMP_STEP(RAMP_STEP)) u_right_ramp (
    .clk(clk), .reset(reset), .wrap_i(wrap), .force_zero_i(force_zero),
    .target_i(right_tgt), .actual_o(right_duty)
  );

  assign left_pwm   = left_pwm_q;
  assign right_pwm  = right_pwm_q;
  assign ctrl_state = state_q;

endmodule
